// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered instruction decoder for the 8-bit accumulator ISA.
// Decodes one instruction per cycle into a control bundle with 1-cycle latency,
// squashes FLUSH_SLOTS wrong-path valid slots after a taken branch, and enters a
// sticky halt state on an accepted halt.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   instr_i, instr_valid_i instruction word and its valid qualifier
//   stall_i                hold all state and outputs (ignored once halted)
//   cb_i                   condition bit, decides brf/brb direction
//   valid_o .. branchb_o   registered control bundle
//   done_o                 sticky halt flag
//   flush_active_o         squash counter is nonzero
module ctrl_decode_pipe #(
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter logic [2:0]  ACC_ADDR    = 3'd7,
    parameter logic [2:0]  SUBS_RS     = 3'd2,
    parameter logic [2:0]  SUBS_RT     = 3'd5,
    parameter logic [2:0]  SLT_RS      = 3'd6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr_i,
    input  logic       instr_valid_i,
    input  logic       stall_i,
    input  logic       cb_i,
    output logic       valid_o,
    output logic [3:0] alucontrol_o,
    output logic [2:0] rs_addr_o,
    output logic [2:0] rt_addr_o,
    output logic [2:0] write_addr_o,
    output logic [4:0] immediate_o,
    output logic       regwrite_o,
    output logic       write_data_control_o,
    output logic       CBwrite_o,
    output logic       memwrite_o,
    output logic       memread_o,
    output logic       branchf_o,
    output logic       branchb_o,
    output logic       done_o,
    output logic       flush_active_o
);

    typedef struct packed {
        logic       valid;
        logic [3:0] alu;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] wa;
        logic [4:0] imm;
        logic       regwrite;
        logic       wdc;
        logic       cbwrite;
        logic       memwrite;
        logic       memread;
        logic       branchf;
        logic       branchb;
    } bundle_t;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    bundle_t    bundle_q, bundle_d;
    bundle_t    dec;
    logic       dec_halt;
    logic       accept;
    logic       upd;
    logic [2:0] instr_r;

    assign instr_r = instr_i[2:0];

    // Pure decode of the current instruction word, qualified later by accept.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec_halt  = 1'b0;
        unique casez (instr_i[7:3])
            5'b00???: begin
                dec.alu = 4'd0; dec.regwrite = 1'b1;
                dec.wa = instr_i[5:3]; dec.rs = instr_r; dec.rt = ACC_ADDR;
            end
            5'b01???: begin
                dec.alu = 4'd1; dec.regwrite = 1'b1;
                dec.wa = instr_i[5:3]; dec.rs = instr_r; dec.rt = ACC_ADDR;
            end
            5'b110??: begin
                dec.alu = 4'd8; dec.regwrite = 1'b1;
                dec.wa = ACC_ADDR; dec.imm = instr_i[4:0];
            end
            5'b11100: begin
                dec.alu = 4'd2; dec.regwrite = 1'b1;
                dec.wa = instr_r; dec.rs = instr_r; dec.rt = ACC_ADDR;
            end
            5'b11101: begin
                dec.alu = 4'd3; dec.regwrite = 1'b1;
                dec.wa = instr_r; dec.rs = instr_r; dec.rt = ACC_ADDR;
            end
            5'b11110: begin
                dec.alu = 4'd1; dec.rs = instr_r; dec.branchf = cb_i;
            end
            5'b11111: begin
                dec.alu = 4'd4; dec.regwrite = 1'b1;
                dec.wa = instr_r; dec.rs = SUBS_RS; dec.rt = SUBS_RT;
            end
            5'b10000: begin
                dec.alu = 4'd5; dec.cbwrite = 1'b1; dec.rs = SLT_RS; dec.rt = ACC_ADDR;
            end
            5'b10001: begin
                dec.alu = 4'd1; dec_halt = 1'b1;
            end
            5'b10010: begin
                dec.alu = 4'd1; dec.regwrite = 1'b1; dec.wdc = 1'b1; dec.memread = 1'b1;
                dec.wa = instr_r; dec.rt = ACC_ADDR;
            end
            5'b10011: begin
                dec.alu = 4'd1; dec.memwrite = 1'b1; dec.rs = instr_r; dec.rt = ACC_ADDR;
            end
            5'b10100: begin
                dec.alu = 4'd6; dec.regwrite = 1'b1; dec.wa = instr_r; dec.rs = instr_r;
            end
            5'b10101: begin
                dec.alu = 4'd7; dec.cbwrite = 1'b1; dec.rs = instr_r; dec.rt = ACC_ADDR;
            end
            5'b10110: begin
                dec.alu = 4'd1; dec.rs = instr_r; dec.branchb = cb_i;
            end
            5'b10111: begin
                dec.alu = 4'd9; dec.regwrite = 1'b1;
                dec.wa = ACC_ADDR; dec.rs = instr_r; dec.rt = ACC_ADDR;
            end
            default: dec = '0;
        endcase
    end

    assign accept = !stall_i && instr_valid_i && (state_q == StRun) && (count_q == 3'd0);
    // Once halted, stall no longer freezes the bundle: it drains to bubbles.
    assign upd    = !stall_i || (state_q == StHalt);

    // State, squash counter and bundle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            count_q  <= 3'd0;
            bundle_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (upd) begin
                bundle_q <= bundle_d;
            end
        end
    end

    // Next-state: FSM and squash counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (state_q == StRun && !stall_i) begin
            if (accept) begin
                if (dec_halt) begin
                    state_d = StHalt;
                end
                if (dec.branchf || dec.branchb) begin
                    count_d = 3'(FLUSH_SLOTS);
                end
            end else if (instr_valid_i && count_q != 3'd0) begin
                // Only valid wrong-path instructions consume a squash slot.
                count_d = count_q - 3'd1;
            end
        end
    end

    // Output: next bundle is the decode when accepted, otherwise an all-zero bubble.
    always_comb begin
        bundle_d = '0;
        if (accept) begin
            bundle_d = dec;
        end
    end

    assign valid_o              = bundle_q.valid;
    assign alucontrol_o         = bundle_q.alu;
    assign rs_addr_o            = bundle_q.rs;
    assign rt_addr_o            = bundle_q.rt;
    assign write_addr_o         = bundle_q.wa;
    assign immediate_o          = bundle_q.imm;
    assign regwrite_o           = bundle_q.regwrite;
    assign write_data_control_o = bundle_q.wdc;
    assign CBwrite_o            = bundle_q.cbwrite;
    assign memwrite_o           = bundle_q.memwrite;
    assign memread_o            = bundle_q.memread;
    assign branchf_o            = bundle_q.branchf;
    assign branchb_o            = bundle_q.branchb;
    assign done_o               = (state_q == StHalt);
    assign flush_active_o       = (count_q != 3'd0);

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Registered, pipelined successor to the combinational instruction decoder for the 8-bit accumulator ISA. It decodes one instruction per cycle into a registered control bundle with 1-cycle latency. Decode honours a valid/stall handshake and squashes a programmable number of wrong-path slots after a taken branch. A sticky halt state replaces the combinational done.

Parameters:
FLUSH_SLOTS, 1, valid instructions squashed after a taken branch (legal range 0..7).
ACC_ADDR, 3'd7, accumulator register address (implicit rt/wa).
SUBS_RS / SUBS_RT, 3'd2 / 3'd5, fixed operand registers for subsigned.
SLT_RS, 3'd6, fixed rs for slt.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_i  in  8  instruction word
instr_valid_i  in  1  instr_i valid this cycle
stall_i  in  1  hold all state and outputs
cb_i  in  1  condition bit from datapath
valid_o  out  1  registered bundle is a live instruction
alucontrol_o  out  4  ALU op
rs_addr_o  out  3  source A
rt_addr_o  out  3  source B
write_addr_o  out  3  destination
immediate_o  out  5  set immediate
regwrite_o  out  1  register write enable
write_data_control_o  out  1  1 = writeback from memory
CBwrite_o  out  1  condition-bit write enable
memwrite_o  out  1  memory write
memread_o  out  1  memory read
branchf_o  out  1  taken forward branch
branchb_o  out  1  taken backward branch
done_o  out  1  sticky halt flag
flush_active_o  out  1  squash counter nonzero

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state RUN; squash count 0.
- Fields not listed for an opcode are 0. Abbreviations: r = instr_i[2:0], ACC = ACC_ADDR.
- Opcode map (instr_i[7:3]):
  - 00???: and, alu 0, regwrite, wa=instr_i[5:3], rs=r, rt=ACC.
  - 01???: add, alu 1, otherwise as and.
  - 110??: set, alu 8, regwrite, wa=ACC, imm=instr_i[4:0].
  - 11100: sll, alu 2, regwrite, wa=rs=r, rt=ACC.
  - 11101: srl, alu 3, regwrite, wa=rs=r, rt=ACC.
  - 11110: brf, alu 1, rs=r, branchf=cb_i.
  - 11111: subs, alu 4, regwrite, wa=r, rs=SUBS_RS, rt=SUBS_RT.
  - 10000: slt, alu 5, CBwrite, rs=SLT_RS, rt=ACC.
  - 10001: halt, alu 1.
  - 10010: load, alu 1, regwrite, write_data_control, memread, wa=r, rt=ACC.
  - 10011: store, alu 1, memwrite, rs=r, rt=ACC.
  - 10100: abs, alu 6, regwrite, wa=rs=r.
  - 10101: seq, alu 7, CBwrite, rs=r, rt=ACC.
  - 10110: brb, alu 1, rs=r, branchb=cb_i.
  - 10111: addc, alu 9, regwrite, wa=ACC, rs=r, rt=ACC.
- Update rule: registers update only when stall_i=0. When stall_i=1, every output, the state and the squash counter hold.
- Accept: stall_i=0, instr_valid_i=1, state RUN, squash count 0. The bundle is registered the next edge with valid_o=1.
- Bubble: stall_i=0 and not accept. All enables (regwrite, CBwrite, memwrite, memread, branchf, branchb) are 0 and valid_o=0. Address, alu and immediate fields are 0.
- Squash: when a valid instruction arrives with count>0, it yields a bubble and count decrements. Invalid cycles do not decrement. A branch inside a squash slot is not taken; a halt inside a squash slot is ignored.
- Taken branch: brf/brb accepted with cb_i=1 sets count=FLUSH_SLOTS on that edge. With FLUSH_SLOTS=0, no slots are squashed. A not-taken branch is a plain valid bubble-equivalent (valid_o=1, no enables).
- flush_active_o = (count != 0), combinational from the counter.
- FSM states:
  - RUN to HALT on an accepted halt; done_o=1 on the same edge the halt bundle registers.
  - HALT: all further cycles are bubbles, done_o stays 1, stall_i is irrelevant. Exit is only via reset.
- Reset mid-squash or in HALT returns to RUN with count 0 immediately, without waiting for a clock edge.

Test Plan:
- Reset then instr 8'h4B (add), valid -> next edge valid_o=1, alu=1, regwrite=1, wa=1, rs=3, rt=7.
- instr 8'hF2 (brf), cb_i=1, FLUSH_SLOTS=1, then 8'h4B, 8'h4B -> branchf_o=1; first add is a bubble with flush_active_o=1 during it; second add has valid_o=1.
- stall_i=1 for 3 cycles mid-stream with the squash count at 1 -> outputs and flush_active_o frozen; the squash resumes after the stall releases.
- 8'h88 (halt) accepted -> done_o=1 next edge; subsequent store 8'h9A gives memwrite_o=0 forever; rst_n low clears done_o asynchronously.
- halt inside a squash slot after taken brb (8'hB1, cb=1) -> done_o stays 0; the following instruction executes.
- 8'h92 (load) -> memread=1, write_data_control=1, regwrite=1, wa=2, rt=7, rs=0; instr_valid_i=0 cycles -> valid_o=0 and all enables 0.
